dispatch8x4: RTL and testbench

Registered 1-to-8 dispatcher for 4-bit words: the transmit-side counterpart of the 8-source, 4-bit OR-combining bus. A single upstream stream (data plus 3-bit destination select) is accepted under a valid/ready handshake. Each word lands in a one-entry holding register for the selected output port, and is presented there under a per-port valid/ready handshake. It sits between a single producer and up to eight consumers whose outputs are later merged back onto one bus by the OR-combiner.

---
 rtl/dispatch8x4.sv | 77 +++++++
 tb/tb_dispatch8x4.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dispatch8x4.sv
`default_nettype none
// ============================================================================
// Module   : dispatch8x4
// Purpose  : Registered 1-to-8 dispatcher for 4-bit words. One upstream
//            valid/ready stream is steered by SEL into one of eight
//            one-entry holding slots, each presented on its own
//            valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch8x4 (
  input  logic       CLK,
  input  logic       ASYNCRESET,
  input  logic [3:0] I,
  input  logic [2:0] SEL,
  input  logic       VALID,
  output logic       READY,
  output logic [3:0] O0,
  output logic [3:0] O1,
  output logic [3:0] O2,
  output logic [3:0] O3,
  output logic [3:0] O4,
  output logic [3:0] O5,
  output logic [3:0] O6,
  output logic [3:0] O7,
  output logic [7:0] OVALID,
  input  logic [7:0] OREADY,
  output logic       BUSY
);

  localparam int unsigned C_PORTS = 8;

  logic [3:0] r_data [C_PORTS];
  logic [7:0] r_full;
  logic       w_acc;
  logic [7:0] w_drn;

  // Upstream handshake: a full slot only accepts when it drains this cycle;
  // READY is held low while reset is asserted.
  always_comb begin
    READY = 1'b0;
    if (!ASYNCRESET) begin
      READY = !r_full[SEL] || OREADY[SEL];
    end
  end

  assign w_acc = VALID & READY;
  assign w_drn = r_full & OREADY;

  // Per-slot holding register: refill wins over drain, drain clears only the
  // full flag and leaves the stale word visible.
  for (genvar k = 0; k < C_PORTS; k++) begin : g_slot
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
        r_data[k] <= 4'h0;
        r_full[k] <= 1'b0;
      end else if (w_acc && (SEL == 3'(k))) begin
        r_data[k] <= I;
        r_full[k] <= 1'b1;
      end else if (w_drn[k]) begin
        r_full[k] <= 1'b0;
      end
    end
  end

  assign O0     = r_data[0];
  assign O1     = r_data[1];
  assign O2     = r_data[2];
  assign O3     = r_data[3];
  assign O4     = r_data[4];
  assign O5     = r_data[5];
  assign O6     = r_data[6];
  assign O7     = r_data[7];
  assign OVALID = r_full;
  assign BUSY   = |r_full;

endmodule
`default_nettype wire

// File: tb/tb_dispatch8x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch8x4
// Purpose  : Self-checking bench for dispatch8x4. Per-port FIFOs of accepted
//            words form the reference; directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch8x4;

  logic       CLK = 1'b0;
  logic       ASYNCRESET = 1'b0;
  logic [3:0] I = 4'h0;
  logic [2:0] SEL = 3'd0;
  logic       VALID = 1'b0;
  logic [7:0] OREADY = 8'h00;
  logic       READY, BUSY;
  logic [3:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic [7:0] OVALID;

  dispatch8x4 dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .SEL(SEL), .VALID(VALID),
    .READY(READY), .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5),
    .O6(O6), .O7(O7), .OVALID(OVALID), .OREADY(OREADY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [3:0] o_arr [8];
  assign o_arr[0] = O0; assign o_arr[1] = O1; assign o_arr[2] = O2; assign o_arr[3] = O3;
  assign o_arr[4] = O4; assign o_arr[5] = O5; assign o_arr[6] = O6; assign o_arr[7] = O7;

  // Reference: words accepted for each port, oldest first, plus the last
  // word ever written to each port (what the output shows once drained).
  logic [3:0] q [8][$];
  logic [3:0] last_w [8];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_full();
    logic [7:0] f = 8'h00;
    for (int k = 0; k < 8; k++) f[k] = (q[k].size() != 0);
    return f;
  endfunction

  task automatic check_outputs(input string where);
    chk({where, "_ovalid"}, OVALID, model_full());
    chk({where, "_busy"}, BUSY, |model_full());
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_o%0d", where, k), o_arr[k], last_w[k]);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic [3:0] d, input logic [2:0] s, input logic [7:0] ordy);
    logic exp_ready;
    VALID = v; I = d; SEL = s; OREADY = ordy;
    #1;
    exp_ready = (q[s].size() == 0) || ordy[s];
    chk("ready", READY, exp_ready);
    chk("busy_pre", BUSY, |model_full());
    for (int k = 0; k < 8; k++) begin
      if (ordy[k] && q[k].size() != 0) begin
        chk($sformatf("deliver_p%0d", k), o_arr[k], q[k][0]);
        void'(q[k].pop_front());
      end
    end
    if (v && exp_ready) begin
      q[s].push_back(d);
      last_w[s] = d;
    end
    @(posedge CLK);
    #1;
    check_outputs("post");
    for (int k = 0; k < 8; k++) chk($sformatf("depth_p%0d", k), q[k].size() <= 1, 1);
    @(negedge CLK);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      q[k].delete();
      last_w[k] = 4'h0;
    end
  endtask

  // Reset asserted between edges, held across one rising edge.
  task automatic do_reset();
    #2;
    ASYNCRESET = 1'b1;
    #1;
    clear_model();
    chk("rst_ready", READY, 1'b0);
    check_outputs("rst_now");
    @(posedge CLK);
    #1;
    chk("rst_ready_hold", READY, 1'b0);
    check_outputs("rst_hold");
    @(negedge CLK);
    ASYNCRESET = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    do_reset();

    // Release with SEL=5: idle dispatcher is ready.
    step(1'b0, 4'h0, 3'd5, 8'h00);

    // Basic routing.
    step(1'b1, 4'hA, 3'd3, 8'h00);
    step(1'b1, 4'h5, 3'd7, 8'h00);
    chk("route_ovalid", OVALID, 8'h88);
    chk("route_o3", O3, 4'hA);
    chk("route_o7", O7, 4'h5);
    step(1'b0, 4'h0, 3'd0, 8'h08);
    chk("route_drain", OVALID, 8'h80);
    step(1'b0, 4'h0, 3'd0, 8'h80);

    // Backpressure on slot 2.
    step(1'b1, 4'h1, 3'd2, 8'h00);
    repeat (5) step(1'b1, 4'h9, 3'd2, 8'h00);
    chk("bp_o2_hold", O2, 4'h1);
    step(1'b1, 4'h9, 3'd2, 8'h04);
    chk("bp_o2_new", O2, 4'h9);
    chk("bp_ovalid2", OVALID[2], 1'b1);
    step(1'b0, 4'h0, 3'd0, 8'h04);

    // Full-rate stream to port 0.
    for (int w = 0; w < 16; w++) step(1'b1, 4'(w), 3'd0, 8'hFF);
    step(1'b0, 4'h0, 3'd0, 8'hFF);

    // Fill all slots, then drain all at once.
    for (int k = 0; k < 8; k++) step(1'b1, 4'(k), 3'(k), 8'h00);
    chk("fill_all", OVALID, 8'hFF);
    step(1'b0, 4'h0, 3'd0, 8'hFF);
    chk("drain_all", OVALID, 8'h00);
    chk("drain_busy", BUSY, 1'b0);

    // Reset mid-operation with a word on offer.
    for (int k = 0; k < 8; k++) step(1'b1, 4'(k + 8), 3'(k), 8'h00);
    VALID = 1'b1; I = 4'hE; SEL = 3'd4; OREADY = 8'hFF;
    do_reset();
    step(1'b0, 4'h0, 3'd4, 8'h00);
    chk("rst_lost_word", OVALID, 8'h00);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step(1'($urandom), 4'($urandom), 3'($urandom), 8'($urandom & $urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
